// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two master request ports and the shared
// bus-interface port of mem_arbiter.
//   slave  modport : arbiter view (takes p0/p1 requests, drives mem_* / grant)
//   master modport : environment view (masters plus bus interface)
//   p0_*/p1_* : read/write strobes, addr, wdata in; done pulse, rdata out
//   p1_lock   : keeps port 1 ownership across completions
//   mem_*     : registered request to the bus interface, rdata/done back
//   grant     : one-hot current owner {p1,p0}
interface mem_arbiter_if #(parameter int ADDR_W = 16);
  logic              p0_read, p0_write;
  logic [ADDR_W-1:0] p0_addr;
  logic [7:0]        p0_wdata;
  logic              p0_done;
  logic [7:0]        p0_rdata;
  logic              p1_read, p1_write, p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [7:0]        p1_wdata;
  logic              p1_done;
  logic [7:0]        p1_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_done;
  logic [1:0]        grant;

  modport slave (
    input  p0_read, p0_write, p0_addr, p0_wdata,
    input  p1_read, p1_write, p1_addr, p1_wdata, p1_lock,
    input  mem_rdata, mem_done,
    output p0_done, p0_rdata, p1_done, p1_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, grant
  );

  modport master (
    output p0_read, p0_write, p0_addr, p0_wdata,
    output p1_read, p1_write, p1_addr, p1_wdata, p1_lock,
    output mem_rdata, mem_done,
    input  p0_done, p0_rdata, p1_done, p1_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one bus-interface request port between port 0 (CPU)
// and port 1 (debug/DMA). One transaction at a time; round-robin or fixed
// priority on ties; port 1 can hold ownership with p1_lock.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (request ports, bus port, grant)
module mem_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int ADDR_W      = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam bit RR = (ROUND_ROBIN != 0);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, LOCKED1} state_t;

  state_t            r_state;
  logic              r_last1;     // 1 = port 1 was granted most recently
  logic              r_mem_read, r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic [1:0]        r_grant;

  logic w_req0, w_req1, w_pick1, w_take0, w_take1;

  assign w_req0 = bus.p0_read | bus.p0_write;
  assign w_req1 = bus.p1_read | bus.p1_write;

  // Tie goes to the port not served last (RR) or to port 0 (fixed).
  assign w_pick1 = w_req1 & (~w_req0 | (RR & ~r_last1));

  // LOCKED1 with lock dropped and port 1 quiet arbitrates like IDLE in the
  // same cycle, so port 0 does not lose an extra cycle.
  assign w_take1 = ((r_state == IDLE) & w_pick1) |
                   ((r_state == LOCKED1) & w_req1);
  assign w_take0 = ((r_state == IDLE) & w_req0 & ~w_pick1) |
                   ((r_state == LOCKED1) & ~w_req1 & ~bus.p1_lock & w_req0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last1     <= 1'b1;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_grant     <= 2'b00;
    end else if (w_take1) begin
      r_state     <= BUSY1;
      r_last1     <= 1'b1;
      r_mem_write <= bus.p1_write;
      r_mem_read  <= bus.p1_read & ~bus.p1_write;  // write wins if both
      r_mem_addr  <= bus.p1_addr;
      r_mem_wdata <= bus.p1_wdata;
      r_grant     <= 2'b10;
    end else if (w_take0) begin
      r_state     <= BUSY0;
      r_last1     <= 1'b0;
      r_mem_write <= bus.p0_write;
      r_mem_read  <= bus.p0_read & ~bus.p0_write;
      r_mem_addr  <= bus.p0_addr;
      r_mem_wdata <= bus.p0_wdata;
      r_grant     <= 2'b01;
    end else begin
      case (r_state)
        BUSY0, BUSY1: begin
          // Requests are ignored while busy; only mem_done ends the cycle.
          if (bus.mem_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_grant     <= 2'b00;
            r_state     <= (r_state == BUSY1 && bus.p1_lock) ? LOCKED1 : IDLE;
          end
        end
        LOCKED1: if (!bus.p1_lock) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.grant     = r_grant;

  // grant is only non-zero while busy, so stray mem_done never leaks out.
  assign bus.p0_done  = bus.mem_done & r_grant[0];
  assign bus.p1_done  = bus.mem_done & r_grant[1];
  assign bus.p0_rdata = bus.mem_rdata;
  assign bus.p1_rdata = bus.mem_rdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single CPU-side memory request port of the bus interface between the CPU core (port 0) and a second bus master such as a debug/DMA engine (port 1). It accepts held read/write requests from both masters, grants one at a time with round-robin or fixed priority, and forwards the winner's request to the bus interface as registered, stable signals. It routes the completion pulse back to the winner only, and supports a lock so port 1 can perform uninterrupted multi-byte sequences.

## Interface
- ROUND_ROBIN, 1, 1 = alternate priority after each served transaction; 0 = port 0 always wins ties
- ADDR_W, 16, address width of all ports
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- p0_read / p0_write  in  1  port 0 request strobes, held until p0_done
- p0_addr  in  ADDR_W  port 0 address, stable while request held
- p0_wdata  in  8  port 0 write data
- p0_done  out  1  one-cycle completion pulse to port 0
- p0_rdata  out  8  read data, valid with p0_done
- p1_read / p1_write / p1_addr / p1_wdata / p1_done / p1_rdata: same as port 0, for port 1
- p1_lock  in  1  when high at port 1 completion, port 1 keeps exclusive ownership
- mem_read / mem_write  out  1  request to bus interface, held until mem_done
- mem_addr  out  ADDR_W  registered address to bus interface
- mem_wdata  out  8  registered write data
- mem_rdata  in  8  read data from bus interface, valid with mem_done
- mem_done  in  1  one-cycle completion pulse from bus interface
- grant  out  2  one-hot current owner ({p1,p0}); 00 when idle

## Operation
- States: IDLE, BUSY0, BUSY1, LOCKED1 (idle but reserved for port 1).
- A port is requesting when read|write is high. If read and write are both high, write is forwarded and read is ignored.
- IDLE:
  - One requester: grant it.
  - Both requesting: winner is the port not served last when ROUND_ROBIN=1; otherwise port 0.
  - On grant: latch addr/wdata/read/write into mem_* registers, set grant, go to BUSYx. The last-served pointer updates at grant.
- BUSYx:
  - mem_* held constant and input requests ignored.
  - On mem_done: clear mem_read/mem_write/grant. Pulse px_done combinationally as mem_done & grant[x].
  - px_rdata = mem_rdata for both ports. Validity is qualified by px_done only.
  - After BUSY1 completes with p1_lock high, next state is LOCKED1; otherwise IDLE.
- LOCKED1:
  - Only port 1 may be granted. Port 0 waits.
  - If p1_lock is low and port 1 is not requesting, return to IDLE in the same evaluation.
- mem_done outside BUSYx is ignored: no px_done, no state change.
- Dropping a request while BUSY has no effect. The transaction completes and the done pulse is still issued.

## Timing
- Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, grant=00, p0_done=p1_done=0, state IDLE, last-served=port 1 (port 0 wins the first tie).
- Request sampled high in IDLE at edge N: mem_* and grant valid from N+1. Request-to-bus latency is 1 cycle.
- mem_done high in cycle M: px_done is high in the same cycle M. mem_read/mem_write/grant are low from M+1.
- From M+1, the arbiter is in IDLE/LOCKED1 and samples requests. A requester that still holds its request in M+1 (has not yet seen done) is treated as a new request.
- Minimum turnaround between consecutive bus transactions is 1 idle cycle.
- Asynchronous rst mid-transaction clears all outputs immediately. No px_done is generated for the aborted transaction.

## Test plan
- Single read, port 0 at addr 0x1234: mem_read high 1 cycle after the request, mem_addr=0x1234. Bus returns 0x5A with mem_done: p0_done pulses once, p0_rdata=0x5A, p1_done stays 0.
- Simultaneous continuous requests from both ports, ROUND_ROBIN=1: grants alternate p0,p1,p0,p1 over 4 transactions. With ROUND_ROBIN=0: port 0 served every time while it keeps requesting.
- Port 1 writes 0xAA to 0x0010 with p1_lock=1, then reads 0x0011, while port 0 requests continuously: both port 1 transactions complete before port 0 is granted. After p1_lock drops, port 0 is granted.
- Port 0 changes p0_addr and deasserts p0_read mid-BUSY0: mem_addr and mem_read stay unchanged until mem_done, and p0_done still pulses.
- rst asserted in the middle of a BUSY1 write: all mem_* outputs and grant go to 0 without waiting for a clock edge, and no p1_done is issued. After release, the first tie goes to port 0.
- Spurious mem_done while in IDLE: no px_done pulse, state unchanged.
